// File: rtl/arb_req_queue.sv
// Four-channel request buffer in front of a round-robin arbiter: per-channel FIFOs raise req,
// and a one-hot grant pops the head word onto a single registered payload/ID output.
module arb_req_queue #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic [3:0]      req,
    input  logic [3:0]      grant,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_id,
    output logic            err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem    [4][DEPTH];
    logic [AW-1:0] wr_ptr [4];
    logic [AW-1:0] rd_ptr [4];
    logic [AW:0]   cnt    [4];

    logic [3:0] push;
    logic [3:0] pop;
    logic [1:0] pop_id;
    logic       grant_onehot;
    logic       err_now;

    // Handshake: a word on channel i is taken at the rising edge where in_valid[i] and
    // in_ready[i] are both high; in_ready comes only from the registered count, so a full
    // FIFO refuses data even in a cycle in which it is also popped. The output side has no
    // ready: the consumer must accept every out_valid cycle.
    always_comb begin
        in_ready     = '0;
        req          = '0;
        push         = '0;
        pop          = '0;
        pop_id       = 2'd0;
        grant_onehot = (grant != 4'd0) && ((grant & (grant - 4'd1)) == 4'd0);
        for (int i = 0; i < 4; i++) begin
            in_ready[i] = (cnt[i] != CNT_FULL) & ~rst;
            req[i]      = (cnt[i] != '0) & ~rst;
            push[i]     = in_valid[i] & in_ready[i];
            pop[i]      = grant_onehot & grant[i] & (cnt[i] != '0);
            if (grant[i]) pop_id = i[1:0];
        end
        // Multi-hot grant, or a grant to a channel with nothing queued.
        err_now = ((grant != 4'd0) && !grant_onehot) || ((grant & ~req) != 4'd0);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= 2'd0;
            err       <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + (AW+1)'(1);
                    2'b01:   cnt[i] <= cnt[i] - (AW+1)'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
            out_valid <= |pop;
            if (|pop) begin
                out_data <= mem[pop_id][rd_ptr[pop_id]];
                out_id   <= pop_id;
            end
            if (err_now) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
// Scoreboard bench for arb_req_queue: per-channel model queues feed an expected-output queue
// that is drained whenever the DUT presents a popped word.
module tb_arb_req_queue;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
  logic [3:0]      in_ready;
  logic [3:0]      req;
  logic [3:0]      grant;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            err;

  int checks = 0;
  int errors = 0;

  logic [DW+1:0] exp_q [$];
  logic [DW-1:0] mq [4][$];

  arb_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req(req), .grant(grant), .out_valid(out_valid), .out_data(out_data),
    .out_id(out_id), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_q.delete();
  endtask

  task automatic push_word(input int ch, input logic [DW-1:0] d);
    in_valid = 4'b0001 << ch;
    in_data[ch*DW +: DW] = d;
    if (mq[ch].size() < DEPTH) mq[ch].push_back(d);
    step();
    in_valid = 4'd0;
  endtask

  task automatic grant_ch(input int ch);
    grant = 4'b0001 << ch;
    exp_q.push_back({2'(ch), mq[ch].pop_front()});
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'd0; grant = 4'd0; in_data = '0;
    step(); step();
    checks++;
    if (req !== 4'd0) begin
      errors++; $display("FAIL reset_req: got %b expected 0000", req);
    end
    checks++;
    if (in_ready !== 4'd0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
    end
    checks++;
    if ({out_valid, err, out_id, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b e=%b id=%0d d=%h expected all 0", out_valid, err, out_id, out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'hF) begin
      errors++; $display("FAIL post_reset_in_ready: got %b expected 1111", in_ready);
    end
    clear_model();
  endtask

  task automatic test_single();
    logic [DW+1:0] e;
    push_word(2, 8'hA5);
    checks++;
    if (req !== 4'b0100) begin
      errors++; $display("FAIL single_req: got %b expected 0100", req);
    end
    grant_ch(2);
    step();
    grant = 4'd0;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {out_id, out_data} !== e) begin
      errors++;
      $display("FAIL single_out: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", out_valid, out_id, out_data, e[DW+1:DW], e[DW-1:0]);
    end
    checks++;
    if (req !== 4'd0) begin
      errors++; $display("FAIL single_req_clear: got %b expected 0000", req);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL single_err: got %b expected 0", err);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_pulse: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_fill();
    logic [DW+1:0] e;
    logic          exp_rdy;
    for (int k = 0; k < 4; k++) begin
      push_word(0, 8'(8'h10 + k));
      exp_rdy = (k < 3);
      checks++;
      if (in_ready[0] !== exp_rdy) begin
        errors++; $display("FAIL fill_in_ready%0d: got %b expected %b", k, in_ready[0], exp_rdy);
      end
    end
    push_word(0, 8'h14);
    checks++;
    if (in_ready[0] !== 1'b0 || req[0] !== 1'b1) begin
      errors++; $display("FAIL fill_full: got rdy=%b req=%b expected 0 1", in_ready[0], req[0]);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL fill_overflow_err: got %b expected 0", err);
    end
    for (int k = 0; k < 4; k++) begin
      grant_ch(0);
      step();
      grant = 4'd0;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_id, out_data} !== e) begin
        errors++;
        $display("FAIL fill_out%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", k, out_valid, out_id, out_data, e[DW+1:DW], e[DW-1:0]);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL fill_gap%0d: got %b expected 0", k, out_valid);
      end
    end
    checks++;
    if (req !== 4'd0) begin
      errors++; $display("FAIL fill_drained: got %b expected 0000", req);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW+1:0] e;
    logic [DW-1:0] d;
    for (int k = 0; k < 3; k++) push_word(1, 8'(8'h20 + k));
    for (int k = 0; k < 6; k++) begin
      d = 8'(8'h23 + k);
      in_valid = 4'b0010;
      in_data[DW +: DW] = d;
      grant_ch(1);
      mq[1].push_back(d);
      step();
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_id, out_data} !== e) begin
        errors++;
        $display("FAIL b2b_out%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", k, out_valid, out_id, out_data, e[DW+1:DW], e[DW-1:0]);
      end
      checks++;
      if (in_ready[1] !== 1'b1 || req[1] !== 1'b1) begin
        errors++; $display("FAIL b2b_level%0d: got rdy=%b req=%b expected 1 1", k, in_ready[1], req[1]);
      end
    end
    in_valid = 4'd0;
    grant = 4'd0;
    step();
    for (int k = 0; k < 3; k++) begin
      grant_ch(1);
      step();
      grant = 4'd0;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_id, out_data} !== e) begin
        errors++;
        $display("FAIL b2b_drain%0d: got v=%b id=%0d d=%h expected v=1 id=%0d d=%h", k, out_valid, out_id, out_data, e[DW+1:DW], e[DW-1:0]);
      end
      step();
    end
    checks++;
    if (req !== 4'd0) begin
      errors++; $display("FAIL b2b_empty: got %b expected 0000", req);
    end
  endtask

  task automatic test_round_robin();
    logic [DW+1:0] e;
    logic [3:0]    seen;
    int            ptr;
    int            outs;
    int            idx;
    in_valid = 4'hF;
    in_data = $urandom();
    for (int i = 0; i < 4; i++) mq[i].push_back(in_data[i*DW +: DW]);
    step();
    in_valid = 4'd0;
    seen = 4'd0; ptr = 0; outs = 0;
    for (int cyc = 0; cyc < 20 && outs < 4; cyc++) begin
      grant = 4'd0;
      idx = -1;
      for (int j = 0; j < 4; j++) begin
        if (idx < 0 && req[(ptr + j) % 4]) idx = (ptr + j) % 4;
      end
      if (idx >= 0) begin
        grant_ch(idx);
        ptr = (idx + 1) % 4;
      end
      step();
      if (out_valid === 1'b1) begin
        outs++;
        e = exp_q.pop_front();
        checks++;
        if ({out_id, out_data} !== e) begin
          errors++;
          $display("FAIL rr_out%0d: got id=%0d d=%h expected id=%0d d=%h", outs, out_id, out_data, e[DW+1:DW], e[DW-1:0]);
        end
        checks++;
        if (seen[out_id]) begin
          errors++; $display("FAIL rr_distinct: got repeated id=%0d expected unique", out_id);
        end
        seen[out_id] = 1'b1;
      end
    end
    grant = 4'd0;
    checks++;
    if (outs != 4) begin
      errors++; $display("FAIL rr_count: got %0d expected 4", outs);
    end
    checks++;
    if (seen !== 4'hF) begin
      errors++; $display("FAIL rr_ids: got %b expected 1111", seen);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL rr_err: got %b expected 0", err);
    end
  endtask

  task automatic test_multi_grant();
    in_valid = 4'b0011;
    in_data = 32'h0000_5A3C;
    step();
    in_valid = 4'd0;
    grant = 4'b0011;
    step();
    grant = 4'd0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL multi_no_pop: got %b expected 0", out_valid);
    end
    checks++;
    if (req !== 4'b0011) begin
      errors++; $display("FAIL multi_counts: got %b expected 0011", req);
    end
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL multi_err: got %b expected 1", err);
    end
    step(); step(); step();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL multi_err_sticky: got %b expected 1", err);
    end
  endtask

  task automatic test_empty_grant_and_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    checks++;
    if (err !== 1'b0 || req !== 4'd0) begin
      errors++; $display("FAIL rst_clear: got err=%b req=%b expected 0 0000", err, req);
    end
    in_valid = 4'b1000;
    in_data = 32'h3C00_0000;
    grant = 4'b1000;
    step();
    in_valid = 4'd0;
    grant = 4'd0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL empty_grant_err: got %b expected 1", err);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL empty_grant_no_pop: got %b expected 0", out_valid);
    end
    checks++;
    if (req !== 4'b1000) begin
      errors++; $display("FAIL empty_grant_push: got %b expected 1000", req);
    end
    in_valid = 4'b0011;
    in_data = 32'h0000_7766;
    step();
    in_valid = 4'd0;
    rst = 1'b1;
    grant = 4'b0001;
    step();
    rst = 1'b0;
    grant = 4'd0;
    checks++;
    if (req !== 4'd0 || out_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b v=%b err=%b expected 0000 0 0", req, out_valid, err);
    end
    grant = 4'b0010;
    step();
    grant = 4'd0;
    checks++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_grant: got err=%b v=%b expected 1 0", err, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_round_robin();
    test_multi_grant();
    test_empty_grant_and_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_req_queue.md
# arb_req_queue

Four-channel request buffer that sits directly upstream of the 4-requester round-robin arbiter. Each channel owns a small FIFO of payload words: a non-empty FIFO raises that channel's `req` bit, and a `grant` pulse from the arbiter pops the head word. The popped word is presented on a single registered output with the winning channel ID, so the arbiter's one-hot grant becomes a serialized payload stream.

## Interface
- `DW`, 8, payload width in bits.
- `DEPTH`, 4, entries per channel FIFO; power of two, at least 2.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  4  per-channel push request.
- `in_data`  in  4*DW  per-channel payload; channel i is `in_data[i*DW +: DW]`.
- `in_ready`  out  4  per-channel FIFO not full.
- `req`  out  4  per-channel FIFO non-empty; drives the arbiter `req`.
- `grant`  in  4  arbiter grant; one-hot or zero, one-cycle pulses.
- `out_valid`  out  1  popped word is valid this cycle.
- `out_data`  out  DW  popped payload.
- `out_id`  out  2  channel index of the popped payload.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Per channel i:
  - Circular buffer of `DEPTH` entries.
  - Write and read pointers of log2(`DEPTH`) bits; each wraps naturally from `DEPTH`-1 to 0.
  - Occupancy counter `cnt[i]` of log2(`DEPTH`)+1 bits, range 0..`DEPTH`.
- Push:
  - Occurs when `in_valid[i] & in_ready[i]`.
  - Writes `in_data` slice i at the write pointer, then increments the write pointer.
- `in_ready[i]` = (`cnt[i]` != `DEPTH`) & ~`rst`.
  - It is computed from the registered count, so there is no same-cycle bypass.
  - A full FIFO deasserts `in_ready` even in a cycle where it is also being popped.
- `req[i]` = (`cnt[i]` != 0), combinational from the registered count.
- Pop:
  - Occurs when `grant` is exactly one-hot at bit i and `cnt[i]` != 0 at the start of the cycle.
  - Reads the entry at the read pointer and increments the read pointer.
- Simultaneous push and pop on one channel: `cnt` is unchanged and both pointers advance.
- Push to one channel and pop from another in the same cycle: the two operations are fully independent.
- Output register:
  - On a pop, the next cycle has `out_valid`=1, `out_data` = the popped entry, `out_id` = i.
  - Otherwise `out_valid`=0, and `out_data`/`out_id` hold their last values.
- The output has no backpressure. The consumer must accept every `out_valid` cycle.
- Errors: the condition is evaluated each cycle; any error sets `err`, which stays set until `rst`. The errors are:
  - `grant` with more than one bit set: no pop occurs.
  - `grant[i]`=1 while `cnt[i]`=0: no pop occurs. A push arriving in that same cycle is still accepted.
  - `in_valid[i]`=1 while `in_ready[i]`=0 is **not** an error; the data is simply not taken.
- The block has no FSM beyond the counters. Correct behaviour with the arbiter relies on that arbiter never granting the same channel on two consecutive cycles. The block tolerates a grant arriving one cycle after the request that caused it.

## Timing
- Reset (`rst`=1 at a rising edge) clears:
  - all pointers and counts to 0;
  - `out_valid`, `out_data`, `out_id`, `err` to 0.
- While `rst` is high, `req`=0 and `in_ready`=0. In the first cycle after reset, `in_ready`=4'b1111.
- Reset mid-operation discards all stored words and any pending output. A grant arriving after reset to a now-empty channel sets `err`.
- Push to `req` latency: a push at edge t gives `req[i]`=1 during cycle t+1.
- Pop to output latency: `grant[i]` sampled at edge t gives `out_valid`=1 with data during cycle t+1.
- End to end through the arbiter (push accepted at edge t):
  - `req` high in cycle t+1;
  - arbiter grant in cycle t+2 at the earliest;
  - `out_valid` in cycle t+3.
- Throughput: one pop per cycle across all channels. Each channel sustains one push per cycle while not full.

## Test plan
- Reset then push 0xA5 on ch2 at cycle 0 -> `req`=4'b0100 in cycle 1. Drive `grant`=4'b0100 in cycle 2 -> `out_valid`=1, `out_data`=0xA5, `out_id`=2 in cycle 3; `req`=0 in cycle 3; `err`=0.
- Push 4 words 0x10..0x13 into ch0 with `DEPTH`=4 -> `in_ready[0]`=0 after the 4th push, and a 5th push is not taken. Grant ch0 four times on non-consecutive cycles -> outputs 0x10,0x11,0x12,0x13 in order, then `req[0]`=0.
- Fill ch1 to 3 entries, then push and grant ch1 in the same cycle for 6 cycles -> `cnt` stays 3, pointers wrap, and output order matches push order.
- Connect to the round-robin arbiter, preload one word on every channel -> 4 outputs, one per channel, each `out_id` distinct, no `err`.
- Drive `grant`=4'b0011 with both FIFOs non-empty -> no `out_valid`, counts unchanged, `err`=1 and held until `rst`.
- Drive `grant`=4'b1000 with ch3 empty -> `err`=1. Then assert `rst` mid-stream with words queued -> all `req`=0, `out_valid`=0, `err`=0 the next cycle.
